// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, 2-bit bimodal BHT and static target
// computation for conditional branches and JAL.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0060,
  parameter int unsigned BHT_IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic        imem_resp_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_read_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        br_pred_o,
  output logic [1:0]  bht_rdata_o
);

  localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OP_JAL      = 7'b1101111;
  localparam logic [1:0]  CTR_WEAK_NT = 2'b01;

  // Word-aligned PC: the two low bits are not stored, so they can never be set.
  logic [31:2] pc_q;
  logic [31:0] pc;
  logic [31:0] next_pc;

  logic [1:0]  bht [BHT_ENTRIES];
  logic [BHT_IDX_BITS-1:0] rd_idx;
  logic [BHT_IDX_BITS-1:0] upd_idx;
  logic [1:0]  upd_ctr;
  logic [1:0]  upd_ctr_nxt;

  logic [6:0]  opcode;
  logic        is_branch;
  logic        is_jal;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] pred_target;
  logic [31:0] pc_plus4;

  // Bits that carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{upd_pc_i[31:BHT_IDX_BITS+2], upd_pc_i[1:0], redirect_pc_i[1:0]};

  assign pc          = {pc_q, 2'b00};
  assign imem_addr_o = pc;
  assign imem_read_o = ~rst;
  assign pc_o        = pc;
  assign instr_o     = imem_rdata_i;
  assign valid_o     = imem_resp_i & ~redirect_i & ~rst;

  // BHT read at the fetch PC; a same-cycle update is only seen next cycle.
  assign rd_idx      = pc[BHT_IDX_BITS+1:2];
  assign bht_rdata_o = bht[rd_idx];

  assign opcode    = imem_rdata_i[6:0];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign br_pred_o = is_jal | (is_branch & bht_rdata_o[1]);

  assign b_imm = {{19{imem_rdata_i[31]}}, imem_rdata_i[31], imem_rdata_i[7],
                  imem_rdata_i[30:25], imem_rdata_i[11:8], 1'b0};
  assign j_imm = {{11{imem_rdata_i[31]}}, imem_rdata_i[31], imem_rdata_i[19:12],
                  imem_rdata_i[20], imem_rdata_i[30:21], 1'b0};

  assign pred_target = pc + (is_jal ? j_imm : b_imm);
  assign pc_plus4    = pc + 32'd4;

  // Next-PC selection in priority order.
  always_comb begin
    next_pc = pc;
    if (redirect_i) begin
      next_pc = redirect_pc_i;
    end else if (stall_i) begin
      next_pc = pc;
    end else if (imem_resp_i && br_pred_o) begin
      next_pc = pred_target;
    end else if (imem_resp_i) begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC[31:2];
    end else begin
      pc_q <= next_pc[31:2];
    end
  end

  // Saturating counter update for the resolved branch.
  assign upd_idx = upd_pc_i[BHT_IDX_BITS+1:2];
  assign upd_ctr = bht[upd_idx];

  always_comb begin
    upd_ctr_nxt = upd_ctr;
    if (upd_taken_i) begin
      if (upd_ctr != 2'b11) upd_ctr_nxt = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr_nxt = upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_WEAK_NT;
    end else if (upd_valid_i) begin
      bht[upd_idx] <= upd_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: table of per-cycle stimulus with
// hand-computed combinational outputs and next PC, plus reset corner cases.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, upd_valid_i, upd_taken_i, imem_resp_i;
  logic [31:0] redirect_pc_i, upd_pc_i, imem_rdata_i;
  logic [31:0] imem_addr_o, pc_o, instr_o;
  logic        imem_read_o, valid_o, br_pred_o;
  logic [1:0]  bht_rdata_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ16 = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JALM8 = 32'hFF9F_F06F;  // jal x0,-8
  localparam logic [31:0] JALR  = 32'h0000_8067;  // jalr x0,0(x1)

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .imem_resp_i(imem_resp_i), .imem_rdata_i(imem_rdata_i),
    .imem_addr_o(imem_addr_o), .imem_read_o(imem_read_o), .pc_o(pc_o),
    .instr_o(instr_o), .valid_o(valid_o), .br_pred_o(br_pred_o),
    .bht_rdata_o(bht_rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        rsp;
    logic [31:0] ins;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] e_pc;
    logic        e_val;
    logic        e_pred;
    logic [1:0]  e_bht;
    logic [31:0] e_nxt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic st, logic rsp,
                              logic [31:0] ins, logic uv, logic [31:0] upc, logic ut,
                              logic [31:0] e_pc, logic e_val, logic e_pred,
                              logic [1:0] e_bht, logic [31:0] e_nxt);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.st = st; v.rsp = rsp; v.ins = ins;
    v.uv = uv; v.upc = upc; v.ut = ut;
    v.e_pc = e_pc; v.e_val = e_val; v.e_pred = e_pred; v.e_bht = e_bht; v.e_nxt = e_nxt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; redirect_i = 0; redirect_pc_i = 0; upd_valid_i = 0;
    upd_pc_i = 0; upd_taken_i = 0; imem_resp_i = 0; imem_rdata_i = NOP;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    imem_resp_i = 1;
    // Reset cycle: no valid, no fetch request.
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_read", 32'(imem_read_o), 32'd0);
    rst = 1'b0;
    imem_resp_i = 0;
    #1 chk("reset_pc", pc_o, 32'h60);

    //               rd rpc            st rsp ins    uv upc       ut  pc            val pred bht    next
    vecs.push_back(mk(0, 0,             0, 1, NOP,   0, 0,        0, 32'h60,        1, 0, 2'b01, 32'h64));
    vecs.push_back(mk(0, 0,             0, 1, NOP,   0, 0,        0, 32'h64,        1, 0, 2'b01, 32'h68));
    vecs.push_back(mk(0, 0,             0, 1, NOP,   0, 0,        0, 32'h68,        1, 0, 2'b01, 32'h6C));
    vecs.push_back(mk(1, 32'h80,        0, 0, NOP,   0, 0,        0, 32'h6C,        0, 0, 2'b01, 32'h80));
    // Weak not-taken branch falls through; same-cycle update reads old value.
    vecs.push_back(mk(0, 0,             0, 1, BEQ16, 1, 32'h80,   1, 32'h80,        1, 0, 2'b01, 32'h84));
    vecs.push_back(mk(1, 32'h80,        0, 0, NOP,   1, 32'h80,   1, 32'h84,        0, 0, 2'b01, 32'h80));
    vecs.push_back(mk(0, 0,             0, 1, BEQ16, 0, 0,        0, 32'h80,        1, 1, 2'b11, 32'h90));
    vecs.push_back(mk(1, 32'h100,       0, 0, NOP,   0, 0,        0, 32'h90,        0, 0, 2'b01, 32'h100));
    vecs.push_back(mk(0, 0,             0, 1, JALM8, 0, 0,        0, 32'h100,       1, 1, 2'b01, 32'hF8));
    // Redirect beats stall; low address bits dropped.
    vecs.push_back(mk(1, 32'h203,       1, 1, NOP,   0, 0,        0, 32'hF8,        0, 0, 2'b01, 32'h200));
    vecs.push_back(mk(0, 0,             1, 1, NOP,   0, 0,        0, 32'h200,       1, 0, 2'b01, 32'h200));
    vecs.push_back(mk(0, 0,             0, 0, NOP,   0, 0,        0, 32'h200,       0, 0, 2'b01, 32'h200));
    // Decrement to 00 and saturate there.
    vecs.push_back(mk(0, 0,             0, 0, NOP,   1, 32'h200,  0, 32'h200,       0, 0, 2'b01, 32'h200));
    vecs.push_back(mk(0, 0,             0, 0, NOP,   1, 32'h200,  0, 32'h200,       0, 0, 2'b00, 32'h200));
    vecs.push_back(mk(0, 0,             0, 0, NOP,   1, 32'h200,  0, 32'h200,       0, 0, 2'b00, 32'h200));
    vecs.push_back(mk(0, 0,             0, 0, NOP,   1, 32'h200,  0, 32'h200,       0, 0, 2'b00, 32'h200));
    // Update proceeds under stall: bump 0x200 back up to 01.
    vecs.push_back(mk(0, 0,             1, 1, NOP,   1, 32'h200,  1, 32'h200,       1, 0, 2'b00, 32'h200));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, NOP,   0, 0,        0, 32'h200,       0, 0, 2'b01, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0,             0, 1, NOP,   0, 0,        0, 32'hFFFF_FFFC, 1, 0, 2'b01, 32'h0));
    vecs.push_back(mk(1, 32'h80,        0, 1, NOP,   0, 0,        0, 32'h0,         0, 0, 2'b01, 32'h80));
    // JALR never predicts even with a strongly-taken counter.
    vecs.push_back(mk(0, 0,             0, 1, JALR,  0, 0,        0, 32'h80,        1, 0, 2'b11, 32'h84));

    foreach (vecs[i]) begin
      @(negedge clk);
      redirect_i = vecs[i].rd;  redirect_pc_i = vecs[i].rpc; stall_i = vecs[i].st;
      imem_resp_i = vecs[i].rsp; imem_rdata_i = vecs[i].ins;
      upd_valid_i = vecs[i].uv; upd_pc_i = vecs[i].upc; upd_taken_i = vecs[i].ut;
      #1;
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].e_pc);
      chk($sformatf("v%0d_read", i), 32'(imem_read_o), 32'd1);
      chk($sformatf("v%0d_instr", i), instr_o, vecs[i].ins);
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_val));
      chk($sformatf("v%0d_pred", i), 32'(br_pred_o), 32'(vecs[i].e_pred));
      chk($sformatf("v%0d_bht", i), 32'(bht_rdata_o), 32'(vecs[i].e_bht));
      @(posedge clk);
      #1 chk($sformatf("v%0d_next", i), pc_o, vecs[i].e_nxt);
    end

    // Reset asserted during stall+redirect with a pending update: all discarded.
    @(negedge clk);
    rst = 1; stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h300;
    upd_valid_i = 1; upd_pc_i = 32'h80; upd_taken_i = 1; imem_resp_i = 1;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_read", 32'(imem_read_o), 32'd0);
    @(negedge clk);
    rst = 0;
    idle();
    #1 chk("mid_rst_pc", pc_o, 32'h60);
    chk("mid_rst_bht_60", 32'(bht_rdata_o), 32'd1);
    @(negedge clk);
    redirect_i = 1; redirect_pc_i = 32'h80;
    @(negedge clk);
    idle();
    #1;
    chk("mid_rst_redir_pc", pc_o, 32'h80);
    chk("mid_rst_bht_80", 32'(bht_rdata_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0060, PC loaded on reset.
REQ-002 Parameter BHT_IDX_BITS, default 6, log2 of BHT entry count (64 entries).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall_i  in  1  hold PC (downstream hazard / IF_ID not loading).
REQ-006 redirect_i  in  1  mispredict resolved downstream; load redirect_pc_i.
REQ-007 redirect_pc_i  in  32  corrected fetch address.
REQ-008 upd_valid_i  in  1  BHT update strobe for a resolved conditional branch.
REQ-009 upd_pc_i  in  32  PC of the resolved branch.
REQ-010 upd_taken_i  in  1  actual branch outcome.
REQ-011 imem_resp_i  in  1  instruction memory data valid this cycle.
REQ-012 imem_rdata_i  in  32  fetched instruction word.
REQ-013 imem_addr_o  out  32  fetch address, equals current PC.
REQ-014 imem_read_o  out  1  fetch request.
REQ-015 pc_o  out  32  PC of instr_o, to IF_ID.
REQ-016 instr_o  out  32  fetched instruction, to IF_ID.
REQ-017 valid_o  out  1  instr_o/pc_o valid; drives IF_ID load.
REQ-018 br_pred_o  out  1  predicted taken for this instruction.
REQ-019 bht_rdata_o  out  2  BHT counter read for this PC, carried down the pipe for update.

Function
REQ-020 PC register SHALL be 32 bits; bits [1:0] SHALL always be 00 (redirect_pc_i[1:0] ignored).
REQ-021 imem_addr_o SHALL equal PC combinationally; imem_read_o SHALL be 1 whenever rst is 0.
REQ-022 pc_o = PC, instr_o = imem_rdata_i, combinational; valid_o = imem_resp_i & ~redirect_i & ~rst.
REQ-023 BHT: 2^BHT_IDX_BITS 2-bit saturating counters, indexed PC[BHT_IDX_BITS+1:2]; combinational read.
REQ-024 bht_rdata_o SHALL be the counter at the current PC index.
REQ-025 Decode on instr_o: B-type = opcode 7'b1100011; JAL = opcode 7'b1101111.
REQ-026 br_pred_o = JAL, or (B-type & bht_rdata_o[1]); 0 for all other opcodes.
REQ-027 Predicted target: B-type -> PC + sign-extended B-immediate; JAL -> PC + sign-extended J-immediate; 32-bit add, wraps modulo 2^32.
REQ-028 Next PC priority: redirect_i -> redirect_pc_i; else stall_i -> hold; else imem_resp_i & br_pred_o -> predicted target; else imem_resp_i -> PC+4; else hold.
REQ-029 PC+4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-030 BHT update on upd_valid_i at clock edge: upd_taken_i=1 -> counter+1 saturating at 2'b11; 0 -> counter-1 saturating at 2'b00; index upd_pc_i[BHT_IDX_BITS+1:2].
REQ-031 Read and update to same index in one cycle: read SHALL return pre-update value; new value visible next cycle.
REQ-032 Update SHALL proceed regardless of stall_i or redirect_i.
REQ-033 JALR and non-branch instructions SHALL never set br_pred_o and SHALL never update the BHT from this block.

Reset
REQ-034 On rst: PC <= RESET_PC; every BHT counter <= 2'b01 (weakly not-taken); rst takes priority over redirect, stall, update.
REQ-035 During rst cycle: valid_o = 0, imem_read_o = 0; first fetch of RESET_PC in the first cycle after rst deasserts.
REQ-036 rst asserted mid-stall or mid-redirect SHALL discard both; BHT updates that cycle SHALL be dropped.

Verification
REQ-037 Reset then imem_resp_i=1 each cycle with NOP (32'h0000_0013) -> pc_o 0x60, 0x64, 0x68; valid_o=1; br_pred_o=0.
REQ-038 PC=0x80, instr B-type imm=+16, counter 2'b01 -> br_pred_o=0, next PC 0x84; after two upd_taken_i=1 updates at 0x80 (counter 2'b11) -> br_pred_o=1, next PC 0x90.
REQ-039 JAL imm=-8 at PC 0x100 -> br_pred_o=1, next PC 0xF8, BHT unchanged.
REQ-040 stall_i=1 with redirect_i=1, redirect_pc_i=0x203 -> next PC 0x200, valid_o=0 that cycle.
REQ-041 Four upd_taken_i=0 updates at one index from 2'b01 -> counter 2'b00 and stays; same-cycle read at that index returns pre-update value.
REQ-042 PC=0xFFFF_FFFC, NOP, imem_resp_i=1 -> next PC 0x0000_0000.
